// File: rtl/falafel_lsu.sv
// falafel_lsu: load/store unit serving the falafel allocator core's header requests
// (LOCK, UNLOCK, LOAD, EDIT_SIZE_AND_NEXT_ADDR, EDIT_NEXT_ADDR) over a single-outstanding
// word memory port, returning a one-cycle header response.
// Ports: clk_i/rst_i (sync, active-high); req_from_core_i/lsu_ready_o (request in, accepted
// when val && ready); rsp_to_core_o (one-cycle val + header, never back-pressured);
// mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o held until mem_gnt_i; mem_rvalid_i/mem_rdata_i
// return read data at least one cycle after the grant.
// Optional build macro FALAFEL_LSU_BACKOFF_EN: exponential backoff between failed lock reads.

package falafel_lsu_pkg;
  localparam int DATA_W = 64;

  typedef logic [2:0] lsu_op_t;
  localparam lsu_op_t OP_LOCK                    = 3'd1;
  localparam lsu_op_t OP_UNLOCK                  = 3'd2;
  localparam lsu_op_t OP_LOAD                    = 3'd3;
  localparam lsu_op_t OP_EDIT_SIZE_AND_NEXT_ADDR = 3'd4;
  localparam lsu_op_t OP_EDIT_NEXT_ADDR          = 3'd5;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] next_addr;
  } header_t;

  typedef struct packed {
    logic    val;
    lsu_op_t lsu_op;
    header_t header;
  } header_req_t;

  typedef struct packed {
    logic    val;
    header_t header;
  } header_rsp_t;
endpackage

module falafel_lsu
  import falafel_lsu_pkg::*;
#(
  parameter logic [DATA_W-1:0] LOCK_ADDR   = '0,
  parameter logic [DATA_W-1:0] NEXT_OFFSET = DATA_W'(DATA_W / 8),
  parameter int                BACKOFF_MAX = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  header_req_t       req_from_core_i,
  output logic              lsu_ready_o,
  output header_rsp_t       rsp_to_core_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  if (BACKOFF_MAX < 1) begin : g_bad_cfg
    $error("falafel_lsu: BACKOFF_MAX must be at least 1");
  end

  typedef enum logic [3:0] {
    IDLE, LD_SIZE, LD_SIZE_W, LD_NEXT, LD_NEXT_W, WR_SIZE, WR_NEXT,
    LK_RD, LK_RD_W, LK_BACKOFF, LK_WR, ULK_WR, RSP
  } state_t;

  state_t            state_q, state_d;
  header_t           hdr_q;
  logic              turn_q;
  logic              accept;
  logic              keep_hdr;
  logic              bo_done;
  logic [DATA_W-1:0] next_field_addr;

  assign accept   = (state_q == IDLE) && !rst_i && req_from_core_i.val;
  // Only LOAD and the two edits return a header; lock traffic responds with zeros.
  assign keep_hdr = (req_from_core_i.lsu_op == OP_LOAD) ||
                    (req_from_core_i.lsu_op == OP_EDIT_SIZE_AND_NEXT_ADDR) ||
                    (req_from_core_i.lsu_op == OP_EDIT_NEXT_ADDR);
  // Wraps modulo 2^DATA_W by construction.
  assign next_field_addr = hdr_q.addr + NEXT_OFFSET;

`ifdef FALAFEL_LSU_BACKOFF_EN
  localparam bit BACKOFF_EN = 1'b1;
  localparam int BO_W       = $clog2(BACKOFF_MAX + 1);

  logic [BO_W-1:0] bo_len_q;
  logic [BO_W-1:0] bo_cnt_q;
  logic [BO_W:0]   bo_len_dbl;

  assign bo_len_dbl = {bo_len_q, 1'b0};
  assign bo_done    = (bo_cnt_q <= BO_W'(1));

  // bo_len_q is the wait to apply after the next failed lock read; it doubles per
  // failure and saturates, and restarts at 1 for every new request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bo_len_q <= BO_W'(1);
      bo_cnt_q <= '0;
    end else begin
      if (accept) begin
        bo_len_q <= BO_W'(1);
      end
      if ((state_q == LK_RD_W) && mem_rvalid_i && (mem_rdata_i != '0)) begin
        bo_cnt_q <= bo_len_q;
        if (bo_len_dbl >= (BO_W + 1)'(BACKOFF_MAX)) begin
          bo_len_q <= BO_W'(BACKOFF_MAX);
        end else begin
          bo_len_q <= bo_len_dbl[BO_W-1:0];
        end
      end else if (state_q == LK_BACKOFF) begin
        bo_cnt_q <= bo_cnt_q - BO_W'(1);
      end
    end
  end
`else
  localparam bit BACKOFF_EN = 1'b0;
  assign bo_done = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // One idle bus cycle between the size read and the next_addr read.
      turn_q  <= (state_q == LD_SIZE_W) && mem_rvalid_i;
      if (accept) begin
        hdr_q <= keep_hdr ? req_from_core_i.header : '0;
      end
      if ((state_q == LD_SIZE_W) && mem_rvalid_i) begin
        hdr_q.size <= mem_rdata_i;
      end
      if ((state_q == LD_NEXT_W) && mem_rvalid_i) begin
        hdr_q.next_addr <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    lsu_ready_o   = 1'b0;
    rsp_to_core_o = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;

    case (state_q)
      IDLE: begin
        lsu_ready_o = 1'b1;
        if (req_from_core_i.val) begin
          case (req_from_core_i.lsu_op)
            OP_LOAD:                    state_d = LD_SIZE;
            OP_EDIT_SIZE_AND_NEXT_ADDR: state_d = WR_SIZE;
            OP_EDIT_NEXT_ADDR:          state_d = WR_NEXT;
            OP_LOCK:                    state_d = LK_RD;
            OP_UNLOCK:                  state_d = ULK_WR;
            default:                    state_d = RSP;
          endcase
        end
      end

      LD_SIZE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = hdr_q.addr;
        if (mem_gnt_i) state_d = LD_SIZE_W;
      end

      LD_SIZE_W: begin
        if (mem_rvalid_i) state_d = LD_NEXT;
      end

      LD_NEXT: begin
        mem_req_o  = !turn_q;
        mem_addr_o = next_field_addr;
        if (!turn_q && mem_gnt_i) state_d = LD_NEXT_W;
      end

      LD_NEXT_W: begin
        if (mem_rvalid_i) state_d = RSP;
      end

      WR_SIZE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = hdr_q.addr;
        mem_wdata_o = hdr_q.size;
        if (mem_gnt_i) state_d = WR_NEXT;
      end

      WR_NEXT: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = next_field_addr;
        mem_wdata_o = hdr_q.next_addr;
        if (mem_gnt_i) state_d = RSP;
      end

      LK_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = LOCK_ADDR;
        if (mem_gnt_i) state_d = LK_RD_W;
      end

      LK_RD_W: begin
        if (mem_rvalid_i) begin
          if (mem_rdata_i != '0) begin
            state_d = BACKOFF_EN ? LK_BACKOFF : LK_RD;
          end else begin
            state_d = LK_WR;
          end
        end
      end

      LK_BACKOFF: begin
        if (bo_done) state_d = LK_RD;
      end

      LK_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = LOCK_ADDR;
        mem_wdata_o = DATA_W'(1);
        if (mem_gnt_i) state_d = RSP;
      end

      ULK_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = LOCK_ADDR;
        mem_wdata_o = '0;
        if (mem_gnt_i) state_d = RSP;
      end

      RSP: begin
        rsp_to_core_o.val    = 1'b1;
        rsp_to_core_o.header = hdr_q;
        state_d              = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Outputs are quiet during the reset cycle regardless of the current state.
    if (rst_i) begin
      state_d       = IDLE;
      lsu_ready_o   = 1'b0;
      rsp_to_core_o = '0;
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      mem_addr_o    = '0;
      mem_wdata_o   = '0;
    end
  end

endmodule

// File: tb/tb_falafel_lsu.sv
module tb_falafel_lsu;
  import falafel_lsu_pkg::*;

  localparam logic [63:0] LOCK_A = 64'h0;
  localparam logic [63:0] NOFF   = 64'h8;

  logic        clk = 1'b0;
  logic        rst;
  header_req_t req;
  logic        ready;
  header_rsp_t rsp;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [63:0] rdata = '0;

  always #5 clk = ~clk;

  falafel_lsu dut (
    .clk_i(clk), .rst_i(rst), .req_from_core_i(req), .lsu_ready_o(ready),
    .rsp_to_core_o(rsp), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_gnt_i(gnt),
    .mem_rvalid_i(rvalid), .mem_rdata_i(rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [63:0] mem [bit [63:0]];
  int          gnt_delay = 0;
  int          wait_cnt = 0;
  bit          spur_gnt = 0;
  int          lock_fail = 0;
  bit          rv_pend = 0;
  logic [63:0] rv_data = '0;
  logic [63:0] rv_addr = '0;
  bit          block_rv_en = 0;
  logic [63:0] block_rv_addr = '0;
  bit          stray = 0;

  function automatic logic [63:0] mrd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  always begin
    @(negedge clk);
    #1;
    rvalid = 1'b0;
    rdata  = '0;
    if (rv_pend && !(block_rv_en && rv_addr == block_rv_addr)) begin
      rvalid = 1'b1;
      rdata  = rv_data;
    end
    if (stray) begin
      rvalid = 1'b1;
      rdata  = 64'h99;
    end
    rv_pend = 0;
    gnt = 1'b0;
    if (mem_req) begin
      if (wait_cnt >= gnt_delay) begin
        gnt = 1'b1;
        wait_cnt = 0;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else begin
          rv_pend = 1;
          rv_addr = mem_addr;
          if (mem_addr == LOCK_A && lock_fail > 0) begin
            rv_data = 64'h1;
            lock_fail--;
          end else rv_data = mrd(mem_addr);
        end
      end else wait_cnt++;
    end else begin
      wait_cnt = 0;
      gnt = spur_gnt;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } txn_t;

  txn_t    exp_txn[$];
  header_t exp_rsp[$];
  txn_t    glog[$];
  int      gcyc[$];
  int      rvcyc[$];
  bit      busy = 0, rd_out = 0, held = 0;
  txn_t    held_t;
  int      cyc = 0;

  function automatic txn_t mk(input logic we, input logic [63:0] a, input logic [63:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  // What an accepted request must do, derived from the operation semantics.
  task automatic expect_op(input lsu_op_t op, input header_t h);
    header_t r;
    r = '0;
    case (op)
      OP_LOAD: begin
        exp_txn.push_back(mk(1'b0, h.addr, '0));
        exp_txn.push_back(mk(1'b0, h.addr + NOFF, '0));
        r.addr = h.addr; r.size = mrd(h.addr); r.next_addr = mrd(h.addr + NOFF);
      end
      OP_EDIT_SIZE_AND_NEXT_ADDR: begin
        exp_txn.push_back(mk(1'b1, h.addr, h.size));
        exp_txn.push_back(mk(1'b1, h.addr + NOFF, h.next_addr));
        r = h;
      end
      OP_EDIT_NEXT_ADDR: begin
        exp_txn.push_back(mk(1'b1, h.addr + NOFF, h.next_addr));
        r = h;
      end
      OP_LOCK: begin
        for (int i = 0; i <= lock_fail; i++) exp_txn.push_back(mk(1'b0, LOCK_A, '0));
        exp_txn.push_back(mk(1'b1, LOCK_A, 64'h1));
      end
      OP_UNLOCK: exp_txn.push_back(mk(1'b1, LOCK_A, 64'h0));
      default: ;
    endcase
    exp_rsp.push_back(r);
  endtask

  always begin
    bit   idle;
    txn_t t, cur;
    @(negedge clk);
    #4;
    cyc++;
    if (rst) begin
      chk("rst_ready", ready, 1'b0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_rsp", rsp, '0);
      busy = 0; rd_out = 0; held = 0;
      exp_txn.delete(); exp_rsp.delete();
    end else begin
      idle = !busy;
      chk("ready", ready, idle);
      if (rvalid && rd_out) begin
        rd_out = 0;
        rvcyc.push_back(cyc);
      end
      cur = mk(mem_we, mem_addr, mem_wdata);
      if (mem_req) begin
        chk("mem_req_legal", busy && !rd_out, 1'b1);
        if (held) chk("mem_hold", cur, held_t);
        if (gnt) begin
          held = 0;
          glog.push_back(cur);
          gcyc.push_back(cyc);
          if (exp_txn.size() == 0) chk("txn_unexpected", 1'b1, 1'b0);
          else begin
            t = exp_txn.pop_front();
            chk("txn_we", mem_we, t.we);
            chk("txn_addr", mem_addr, t.addr);
            if (t.we) chk("txn_wdata", mem_wdata, t.wdata);
            if (!mem_we) rd_out = 1;
          end
        end else begin
          held = 1;
          held_t = cur;
        end
      end else if (held) begin
        chk("mem_req_dropped", mem_req, 1'b1);
        held = 0;
      end
      if (rsp.val) begin
        chk("rsp_while_busy", busy, 1'b1);
        chk("rsp_expected", exp_rsp.size() > 0, 1'b1);
        if (exp_rsp.size() > 0) chk("rsp_hdr", rsp.header, exp_rsp.pop_front());
        chk("rsp_txn_left", exp_txn.size(), 0);
        busy = 0;
      end
      if (req.val && idle) begin
        expect_op(req.lsu_op, req.header);
        busy = 1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input lsu_op_t op, input header_t h, output int lat, output header_t got);
    int n;
    glog.delete(); gcyc.delete(); rvcyc.delete();
    @(negedge clk);
    req.val = 1'b1; req.lsu_op = op; req.header = h;
    n = 0;
    #4;
    while (!ready && n < 100) begin
      @(negedge clk); #4; n++;
    end
    lat = -1;
    got = '0;
    if (!ready) begin
      chk("accept_timeout", 1'b0, 1'b1);
      @(negedge clk);
      req = '0;
    end else begin
      @(negedge clk);
      req = '0;
      #4;
      lat = 1;
      while (!rsp.val && lat < 300) begin
        @(negedge clk); #4; lat++;
      end
      if (!rsp.val) chk("rsp_timeout", 1'b0, 1'b1);
      got = rsp.header;
    end
  endtask

  initial begin
    int      lat;
    header_t got, h;
    bit      found;
    int      n;
    int      exp_gap[3];

    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    chk("ready_after_reset", ready, 1'b1);

    // unknown op: straight to response
    h = {64'h123, 64'h5, 64'h6};
    issue(3'd7, h, lat, got);
    chk("unk_lat", lat, 1);
    chk("unk_hdr", got, '0);
    chk("unk_no_mem", glog.size(), 0);

    // LOAD
    mem[64'h10] = 64'd40;
    mem[64'h18] = 64'd0;
    h = {64'h10, 64'h0, 64'h0};
    issue(OP_LOAD, h, lat, got);
    chk("load_lat", lat, 6);
    chk("load_hdr", got, {64'h10, 64'd40, 64'd0});
    chk("load_nreads", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("load_addr0", glog[0].addr, 64'h10);
      chk("load_addr1", glog[1].addr, 64'h18);
    end

    // EDIT_SIZE_AND_NEXT_ADDR with slow grants
    gnt_delay = 3;
    h = {64'h10, 64'd16, 64'h60};
    issue(OP_EDIT_SIZE_AND_NEXT_ADDR, h, lat, got);
    gnt_delay = 0;
    chk("esn_lat", lat, 9);
    chk("esn_hdr", got, {64'h10, 64'd16, 64'h60});
    chk("esn_mem_size", mrd(64'h10), 64'd16);
    chk("esn_mem_next", mrd(64'h18), 64'h60);

    // LOAD again with grants asserted while no request is pending
    spur_gnt = 1;
    h = {64'h10, 64'h0, 64'h0};
    issue(OP_LOAD, h, lat, got);
    spur_gnt = 0;
    chk("load2_lat", lat, 6);
    chk("load2_hdr", got, {64'h10, 64'd16, 64'h60});

    // contended LOCK
`ifdef FALAFEL_LSU_BACKOFF_EN
    exp_gap = '{1, 2, 4};
`else
    exp_gap = '{0, 0, 0};
`endif
    mem[LOCK_A] = 64'h0;
    lock_fail = 3;
    issue(OP_LOCK, '0, lat, got);
    chk("lock_hdr", got, '0);
    chk("lock_ngrants", glog.size(), 5);
    chk("lock_nrvalid", rvcyc.size(), 4);
    if (glog.size() == 5 && rvcyc.size() == 4) begin
      for (int i = 0; i < 3; i++) chk("lock_gap", gcyc[i+1] - rvcyc[i] - 1, exp_gap[i]);
      chk("lock_final_wr", glog[4], {1'b1, LOCK_A, 64'h1});
    end
    chk("lock_mem", mrd(LOCK_A), 64'h1);

    // EDIT_NEXT_ADDR then UNLOCK back-to-back
    mem[64'h48] = 64'h5;
    h = {64'h40, 64'h0, 64'h0};
    issue(OP_EDIT_NEXT_ADDR, h, lat, got);
    chk("en_lat", lat, 2);
    chk("en_hdr", got, {64'h40, 64'h0, 64'h0});
    chk("en_mem", mrd(64'h48), 64'h0);
    issue(OP_UNLOCK, '0, lat, got);
    chk("ulk_lat", lat, 2);
    chk("ulk_hdr", got, '0);
    chk("ulk_mem", mrd(LOCK_A), 64'h0);

    // next_addr field address wraps past the top of the address space
    h = {64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h77};
    issue(OP_EDIT_NEXT_ADDR, h, lat, got);
    chk("wrap_addr", (glog.size() == 1) ? glog[0].addr : 64'hDEAD, 64'h4);
    chk("wrap_mem", mrd(64'h4), 64'h77);

    // reset while waiting for the next_addr read data
    block_rv_en = 1;
    block_rv_addr = 64'h18;
    @(negedge clk);
    req.val = 1'b1; req.lsu_op = OP_LOAD; req.header = {64'h10, 64'h0, 64'h0};
    #4;
    chk("rst_test_accept", ready, 1'b1);
    @(negedge clk);
    req = '0;
    found = 0;
    n = 0;
    #4;
    while (!found && n < 50) begin
      if (mem_req && gnt && mem_addr == 64'h18) found = 1;
      else begin
        @(negedge clk); #4; n++;
      end
    end
    chk("rst_test_reach", found, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk("post_rst_ready", ready, 1'b1);
    chk("post_rst_mem_req", mem_req, 1'b0);
    chk("post_rst_rsp", rsp.val, 1'b0);
    @(negedge clk);
    stray = 1;
    #4;
    chk("stray_rsp0", rsp.val, 1'b0);
    @(negedge clk);
    stray = 0;
    block_rv_en = 0;
    #4;
    chk("stray_rsp1", rsp.val, 1'b0);
    chk("stray_ready", ready, 1'b1);

    // recovery
    issue(OP_LOAD, {64'h10, 64'h0, 64'h0}, lat, got);
    chk("recover_lat", lat, 6);
    chk("recover_hdr", got, {64'h10, 64'd16, 64'h60});

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/falafel_lsu.md
Name: falafel_lsu

Overview:
Load/store unit that responds to the falafel allocator core's header requests. It accepts one header_req_t at a time and performs the matching word accesses on a single-outstanding memory port: LOCK, UNLOCK, LOAD, EDIT_SIZE_AND_NEXT_ADDR and EDIT_NEXT_ADDR. It returns a one-cycle header_rsp_t to the core. It sits between the core and the heap memory/interconnect.

Parameters:
LOCK_ADDR, 'h0, byte address of the heap lock word.
NEXT_OFFSET, DATA_W/8, byte offset of the next_addr field from the header base (the size field is at offset 0).
BACKOFF_MAX, 64, upper bound in cycles of the lock-retry backoff (used only with the optional feature).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_from_core_i  in  header_req_t  request from core: val, lsu_op, header{addr,size,next_addr}
lsu_ready_o  out  1  LSU can accept a request this cycle
rsp_to_core_o  out  header_rsp_t  response to core: val, header
mem_req_o  out  1  memory request valid
mem_we_o  out  1  1 = write, 0 = read
mem_addr_o  out  DATA_W  byte address
mem_wdata_o  out  DATA_W  write data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  DATA_W  read data

Behaviour:
- Reset values: lsu_ready_o=0 in the reset cycle; all other outputs 0 (rsp val=0, header='0). In the first cycle after reset: state IDLE, lsu_ready_o=1.
- Accept: a request is accepted when req_from_core_i.val && lsu_ready_o. The LSU latches lsu_op and header on acceptance.
- lsu_ready_o=1 only in IDLE. It drops in the cycle after acceptance and stays 0 until the cycle after the rsp pulse.
- Memory port:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable until mem_gnt_i.
  - A write completes on gnt.
  - A read completes on the first mem_rvalid_i at least 1 cycle after gnt.
  - At most one transaction is outstanding. mem_req_o=0 while awaiting rvalid.
- States: IDLE, LD_SIZE, LD_SIZE_W, LD_NEXT, LD_NEXT_W, WR_SIZE, WR_NEXT, LK_RD, LK_RD_W, LK_BACKOFF, LK_WR, ULK_WR, RSP.
- Operation sequences:
  - LOAD: read at addr → size, then read at addr+NEXT_OFFSET → next_addr, then RSP. The rsp header is {addr=req addr, size, next_addr}.
  - EDIT_SIZE_AND_NEXT_ADDR: write size at addr, then write next_addr at addr+NEXT_OFFSET, then RSP. The rsp header echoes the request.
  - EDIT_NEXT_ADDR: single write of next_addr at addr+NEXT_OFFSET, then RSP. The rsp header echoes the request.
  - LOCK: read LOCK_ADDR.
    - If the value is nonzero, go to LK_BACKOFF (0 cycles without the feature), then retry LK_RD.
    - If zero, write 1 to LOCK_ADDR, then RSP.
    - The rsp header is '0.
  - UNLOCK: write 0 to LOCK_ADDR, then RSP. The rsp header is '0.
  - Unknown lsu_op: no memory access, go directly to RSP with header '0.
- RSP: rsp_to_core_o.val=1 for exactly one cycle, then IDLE. The rsp is never back-pressured.
- Address arithmetic: addr+NEXT_OFFSET is modulo 2^DATA_W and wraps silently.
- Minimum latency, acceptance to rsp.val, with gnt same-cycle and rvalid 1 cycle after gnt:
  - LOAD: 6 cycles.
  - EDIT_SIZE_AND_NEXT_ADDR: 3 cycles.
  - EDIT_NEXT_ADDR, UNLOCK: 2 cycles.
  - LOCK (uncontended): 4 cycles.
- req_from_core_i.val while not ready: ignored. The core must hold or re-issue the request.
- mem_rvalid_i outside a read-wait state: ignored.
- mem_gnt_i while mem_req_o=0: ignored.
- Reset mid-operation: next cycle is IDLE with mem_req_o=0 and no rsp. Late rvalid after reset is ignored.

Optional Feature:
FALAFEL_LSU_BACKOFF_EN.
- Defined: LK_BACKOFF waits a delay before re-reading.
  - The delay starts at 1 cycle and doubles on each failed lock read, saturating at BACKOFF_MAX.
  - The delay resets to 1 on acceptance of a new request.
- Undefined: LK_BACKOFF is bypassed and LK_RD re-issues in the cycle after the failing rvalid.

Test Plan:
- LOAD addr='h10; memory ['h10]=40, ['h18]=0 (NEXT_OFFSET=8); gnt immediate, rvalid +1 → reads at 'h10 then 'h18; rsp.val one cycle with header {'h10,40,0}, 6 cycles after acceptance.
- EDIT_SIZE_AND_NEXT_ADDR {addr='h10,size=16,next='h60}, gnt delayed 3 cycles each → writes 16@'h10, then 'h60@'h18; address and data stable while waiting; rsp echoes the request.
- LOCK with [LOCK_ADDR]=1 for 3 reads then 0 → 4 reads, then write 1@'h0, then rsp header '0. With FALAFEL_LSU_BACKOFF_EN, backoff gaps are 1, 2, 4 cycles; without it, gaps are 0.
- EDIT_NEXT_ADDR {addr='h40,next='h0} then UNLOCK back-to-back → one write 0@'h48; rsp; lsu_ready_o returns; write 0@LOCK_ADDR; rsp. lsu_ready_o=0 throughout each operation.
- rst_i asserted during LD_NEXT_W → next cycle IDLE, mem_req_o=0, lsu_ready_o=1; a stray rvalid 2 cycles later produces no rsp.
- Unknown lsu_op → no mem_req_o; rsp.val 1 cycle after acceptance with header '0.
